pipe_hazard_ctrl: RTL and testbench

Central pipeline-control block for the 5-stage RV32 core. It produces all enable and flush strobes for the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers. It resolves load-use interlocks, taken-branch squashes and multi-cycle data-memory waits, and runs a wait-timeout watchdog. It also keeps saturating stall and flush performance counters.

---
 rtl/pipe_hazard_ctrl.sv | 158 +++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// pipe_hazard_ctrl - RV32 5-stage pipeline control: enables, flushes, watchdog
// Rev 1.0
// ============================================================================
module pipe_hazard_ctrl #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       rs1_ID,
  input  logic [4:0]       rs2_ID,
  input  logic             use_rs1_ID,
  input  logic             use_rs2_ID,
  input  logic [4:0]       rd_EX,
  input  logic             memread_EX,
  input  logic             branch_taken_EX,
  input  logic             dmem_req_MEM,
  input  logic             dmem_ready,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             ifid_flush,
  output logic             idex_en,
  output logic             idex_flush,
  output logic             exmem_en,
  output logic             memwb_flush,
  output logic [1:0]       state,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam int WAIT_W = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);

  localparam logic [1:0] C_RUN      = 2'd0;
  localparam logic [1:0] C_MEM_WAIT = 2'd1;
  localparam logic [1:0] C_ERROR    = 2'd2;

  localparam logic [WAIT_W-1:0] C_TIMEOUT = WAIT_W'(TIMEOUT);

  logic [1:0]        state_q, state_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic              mem_timeout_q, mem_timeout_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0]  flush_cnt_q, flush_cnt_d;

  logic w_in_error;
  logic w_mem_stall;
  logic w_load_use;
  logic w_branch_cycle;

  assign w_in_error  = (state_q == C_ERROR);
  assign w_mem_stall = dmem_req_MEM && !dmem_ready;
  assign w_load_use  = memread_EX && (rd_EX != 5'd0) &&
                       ((use_rs1_ID && (rs1_ID == rd_EX)) ||
                        (use_rs2_ID && (rs2_ID == rd_EX)));
  // A branch held during a memory stall only takes effect once the stall clears.
  assign w_branch_cycle = branch_taken_EX && !w_mem_stall && !w_in_error;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= C_RUN;
      wait_cnt_q    <= '0;
      mem_timeout_q <= 1'b0;
      stall_cnt_q   <= '0;
      flush_cnt_q   <= '0;
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      mem_timeout_q <= mem_timeout_d;
      stall_cnt_q   <= stall_cnt_d;
      flush_cnt_q   <= flush_cnt_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d       = state_q;
    wait_cnt_d    = wait_cnt_q;
    mem_timeout_d = mem_timeout_q;
    case (state_q)
      C_RUN: begin
        if (w_mem_stall) begin
          state_d    = C_MEM_WAIT;
          wait_cnt_d = WAIT_W'(1);
        end
      end
      C_MEM_WAIT: begin
        if (w_mem_stall) begin
          if (wait_cnt_q == C_TIMEOUT) begin
            state_d       = C_ERROR;
            mem_timeout_d = 1'b1;
          end else begin
            wait_cnt_d = wait_cnt_q + WAIT_W'(1);
          end
        end else begin
          state_d    = C_RUN;
          wait_cnt_d = '0;
        end
      end
      C_ERROR: begin
        state_d = C_ERROR;
      end
      default: begin
        state_d    = C_RUN;
        wait_cnt_d = '0;
      end
    endcase
  end

  // Output logic
  always_comb begin
    pc_en       = 1'b1;
    ifid_en     = 1'b1;
    ifid_flush  = 1'b0;
    idex_en     = 1'b1;
    idex_flush  = 1'b0;
    exmem_en    = 1'b1;
    memwb_flush = 1'b0;
    if (rst) begin
      ifid_flush  = 1'b1;
      idex_flush  = 1'b1;
      memwb_flush = 1'b1;
    end else if (w_in_error || w_mem_stall) begin
      pc_en       = 1'b0;
      ifid_en     = 1'b0;
      idex_en     = 1'b0;
      exmem_en    = 1'b0;
      memwb_flush = 1'b1;
    end else if (branch_taken_EX) begin
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else if (w_load_use) begin
      pc_en      = 1'b0;
      ifid_en    = 1'b0;
      idex_flush = 1'b1;
    end
  end

  // Saturating performance counters, frozen in ERROR
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (!w_in_error && !pc_en && (stall_cnt_q != '1))
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    if (w_branch_cycle && (flush_cnt_q != '1))
      flush_cnt_d = flush_cnt_q + CNT_W'(1);
  end

  assign state       = state_q;
  assign mem_timeout = mem_timeout_q;
  assign stall_cnt   = stall_cnt_q;
  assign flush_cnt   = flush_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// tb_pipe_hazard_ctrl - directed bench: main instance TIMEOUT=8, watchdog
// instance TIMEOUT=4 with 3-bit counters for saturation. Rev 1.0
// ============================================================================
module tb_pipe_hazard_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic [4:0] rs1_ID, rs2_ID, rd_EX;
  logic       use_rs1_ID, use_rs2_ID, memread_EX, branch_taken_EX;
  logic       dmem_req_MEM, dmem_ready;

  logic        u_pc_en, u_ifid_en, u_ifid_flush, u_idex_en, u_idex_flush, u_exmem_en, u_memwb_flush;
  logic [1:0]  u_state;
  logic        u_mem_timeout;
  logic [31:0] u_stall_cnt, u_flush_cnt;

  logic        w_pc_en, w_ifid_en, w_ifid_flush, w_idex_en, w_idex_flush, w_exmem_en, w_memwb_flush;
  logic [1:0]  w_state;
  logic        w_mem_timeout;
  logic [2:0]  w_stall_cnt, w_flush_cnt;

  // {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_flush}
  logic [6:0] u_ctrl, w_ctrl;
  assign u_ctrl = {u_pc_en, u_ifid_en, u_ifid_flush, u_idex_en, u_idex_flush, u_exmem_en, u_memwb_flush};
  assign w_ctrl = {w_pc_en, w_ifid_en, w_ifid_flush, w_idex_en, w_idex_flush, w_exmem_en, w_memwb_flush};

  localparam logic [6:0] C_DEF = 7'b1101010;
  localparam logic [6:0] C_FRZ = 7'b0000001;
  localparam logic [6:0] C_BR  = 7'b1111110;
  localparam logic [6:0] C_LU  = 7'b0001110;
  localparam logic [6:0] C_RST = 7'b1111111;

  pipe_hazard_ctrl #(.TIMEOUT(8), .CNT_W(32)) u_dut (
    .clk(clk), .rst(rst),
    .rs1_ID(rs1_ID), .rs2_ID(rs2_ID), .use_rs1_ID(use_rs1_ID), .use_rs2_ID(use_rs2_ID),
    .rd_EX(rd_EX), .memread_EX(memread_EX), .branch_taken_EX(branch_taken_EX),
    .dmem_req_MEM(dmem_req_MEM), .dmem_ready(dmem_ready),
    .pc_en(u_pc_en), .ifid_en(u_ifid_en), .ifid_flush(u_ifid_flush),
    .idex_en(u_idex_en), .idex_flush(u_idex_flush), .exmem_en(u_exmem_en),
    .memwb_flush(u_memwb_flush), .state(u_state), .mem_timeout(u_mem_timeout),
    .stall_cnt(u_stall_cnt), .flush_cnt(u_flush_cnt)
  );

  pipe_hazard_ctrl #(.TIMEOUT(4), .CNT_W(3)) u_wd (
    .clk(clk), .rst(rst),
    .rs1_ID(rs1_ID), .rs2_ID(rs2_ID), .use_rs1_ID(use_rs1_ID), .use_rs2_ID(use_rs2_ID),
    .rd_EX(rd_EX), .memread_EX(memread_EX), .branch_taken_EX(branch_taken_EX),
    .dmem_req_MEM(dmem_req_MEM), .dmem_ready(dmem_ready),
    .pc_en(w_pc_en), .ifid_en(w_ifid_en), .ifid_flush(w_ifid_flush),
    .idex_en(w_idex_en), .idex_flush(w_idex_flush), .exmem_en(w_exmem_en),
    .memwb_flush(w_memwb_flush), .state(w_state), .mem_timeout(w_mem_timeout),
    .stall_cnt(w_stall_cnt), .flush_cnt(w_flush_cnt)
  );

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    rs1_ID = 5'd0; rs2_ID = 5'd0; rd_EX = 5'd0;
    use_rs1_ID = 1'b0; use_rs2_ID = 1'b0; memread_EX = 1'b0;
    branch_taken_EX = 1'b0; dmem_req_MEM = 1'b0; dmem_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    idle();
    #1;
    chk("rst_ctrl", 32'(u_ctrl), 32'(C_RST));
    tick();
    rst = 1'b0;
    #1;
    chk("reset_state", 32'(u_state), 32'd0);
    chk("reset_timeout", 32'(u_mem_timeout), 32'd0);
    chk("reset_stall_cnt", u_stall_cnt, 32'd0);
    chk("reset_flush_cnt", u_flush_cnt, 32'd0);
    chk("idle_ctrl", 32'(u_ctrl), 32'(C_DEF));

    // Load-use through rs2
    memread_EX = 1'b1; rd_EX = 5'd5; rs2_ID = 5'd5; use_rs2_ID = 1'b1;
    #1;
    chk("lu_rs2_ctrl", 32'(u_ctrl), 32'(C_LU));
    tick();
    idle();
    #1;
    chk("lu_rs2_stall_cnt", u_stall_cnt, 32'd1);
    chk("lu_after_ctrl", 32'(u_ctrl), 32'(C_DEF));

    // Same hazard on x0 is not a hazard
    memread_EX = 1'b1; rd_EX = 5'd0; rs2_ID = 5'd0; use_rs2_ID = 1'b1;
    #1;
    chk("lu_x0_ctrl", 32'(u_ctrl), 32'(C_DEF));
    tick();
    chk("lu_x0_stall_cnt", u_stall_cnt, 32'd1);

    // rs1 match only counts when rs1 is used
    idle();
    memread_EX = 1'b1; rd_EX = 5'd7; rs1_ID = 5'd7; use_rs1_ID = 1'b0;
    #1;
    chk("lu_rs1_unused_ctrl", 32'(u_ctrl), 32'(C_DEF));
    use_rs1_ID = 1'b1;
    #1;
    chk("lu_rs1_ctrl", 32'(u_ctrl), 32'(C_LU));
    tick();
    idle();
    #1;
    chk("lu_rs1_stall_cnt", u_stall_cnt, 32'd2);

    // Branch overrides load-use
    memread_EX = 1'b1; rd_EX = 5'd5; rs2_ID = 5'd5; use_rs2_ID = 1'b1; branch_taken_EX = 1'b1;
    #1;
    chk("br_lu_ctrl", 32'(u_ctrl), 32'(C_BR));
    tick();
    idle();
    #1;
    chk("br_lu_flush_cnt", u_flush_cnt, 32'd1);
    chk("br_lu_stall_cnt", u_stall_cnt, 32'd2);

    // Three-cycle memory wait then ready
    dmem_req_MEM = 1'b1; dmem_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("mw_ctrl", 32'(u_ctrl), 32'(C_FRZ));
      chk("mw_state", 32'(u_state), (i == 0) ? 32'd0 : 32'd1);
      tick();
    end
    dmem_ready = 1'b1;
    #1;
    chk("mw_ready_ctrl", 32'(u_ctrl), 32'(C_DEF));
    chk("mw_ready_state", 32'(u_state), 32'd1);
    tick();
    idle();
    #1;
    chk("mw_done_state", 32'(u_state), 32'd0);
    chk("mw_stall_cnt", u_stall_cnt, 32'd5);

    // Branch held through a two-cycle wait
    dmem_req_MEM = 1'b1; dmem_ready = 1'b0; branch_taken_EX = 1'b1;
    for (int i = 0; i < 2; i++) begin
      #1;
      chk("bw_ctrl", 32'(u_ctrl), 32'(C_FRZ));
      tick();
    end
    dmem_ready = 1'b1;
    #1;
    chk("bw_ready_ctrl", 32'(u_ctrl), 32'(C_BR));
    tick();
    idle();
    #1;
    chk("bw_flush_cnt", u_flush_cnt, 32'd2);
    chk("bw_stall_cnt", u_stall_cnt, 32'd7);
    chk("bw_state", 32'(u_state), 32'd0);

    // TIMEOUT=4: ready in cycle 4 avoids ERROR
    dmem_req_MEM = 1'b1; dmem_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      chk("wd_ok_state", 32'(w_state), (i == 0) ? 32'd0 : 32'd1);
      tick();
    end
    dmem_ready = 1'b1;
    #1;
    chk("wd_ok_c4_state", 32'(w_state), 32'd1);
    chk("wd_ok_c4_ctrl", 32'(w_ctrl), 32'(C_DEF));
    tick();
    idle();
    #1;
    chk("wd_ok_state_run", 32'(w_state), 32'd0);
    chk("wd_ok_timeout", 32'(w_mem_timeout), 32'd0);
    chk("wd_sat_stall_cnt", 32'(w_stall_cnt), 32'd7);
    chk("wd_main_stall_cnt", u_stall_cnt, 32'd11);

    // TIMEOUT=4: ready never comes
    dmem_req_MEM = 1'b1; dmem_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("wd_err_wait_state", 32'(w_state), (i == 0) ? 32'd0 : 32'd1);
      chk("wd_err_wait_ctrl", 32'(w_ctrl), 32'(C_FRZ));
      tick();
    end
    chk("wd_err_state", 32'(w_state), 32'd2);
    chk("wd_err_timeout", 32'(w_mem_timeout), 32'd1);
    idle();
    branch_taken_EX = 1'b1;
    #1;
    chk("wd_err_ctrl", 32'(w_ctrl), 32'(C_FRZ));
    tick();
    branch_taken_EX = 1'b0;
    #1;
    chk("wd_err_hold_state", 32'(w_state), 32'd2);
    chk("wd_err_flush_frozen", 32'(w_flush_cnt), 32'd2);

    // Reset out of ERROR
    rst = 1'b1;
    #1;
    chk("wd_rst_ctrl", 32'(w_ctrl), 32'(C_RST));
    tick();
    rst = 1'b0;
    #1;
    chk("wd_rst_state", 32'(w_state), 32'd0);
    chk("wd_rst_timeout", 32'(w_mem_timeout), 32'd0);
    chk("wd_rst_stall_cnt", 32'(w_stall_cnt), 32'd0);
    chk("wd_rst_flush_cnt", 32'(w_flush_cnt), 32'd0);
    chk("wd_rst_ctrl_idle", 32'(w_ctrl), 32'(C_DEF));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
